// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: issue, stall, flush and decode-operand signals plus pipeline status
// Ports (master = fetch/decode side, slave = hazard controller):
//   issueValid/issueReady, stallRequest[STAGES], flushValid, flushStage,
//   decodeReadId[READ_PORTS*REG_ID_WIDTH], decodeWriteId, decodeWriteEnabled, decodeIsLoad,
//   stageValid, stageAdvance, hazardStall, forwardSelect[READ_PORTS*clog2(STAGES+1)], retireValid
interface pipeline_hazard_controller_if #(
    parameter int STAGES       = 5,
    parameter int READ_PORTS   = 2,
    parameter int REG_ID_WIDTH = 5
);
    localparam int STAGE_W = $clog2(STAGES);
    localparam int FWD_W   = $clog2(STAGES + 1);
    logic                               issueValid;
    logic                               issueReady;
    logic [STAGES-1:0]                  stallRequest;
    logic                               flushValid;
    logic [STAGE_W-1:0]                 flushStage;
    logic [READ_PORTS*REG_ID_WIDTH-1:0] decodeReadId;
    logic [REG_ID_WIDTH-1:0]            decodeWriteId;
    logic                               decodeWriteEnabled;
    logic                               decodeIsLoad;
    logic [STAGES-1:0]                  stageValid;
    logic [STAGES-1:0]                  stageAdvance;
    logic                               hazardStall;
    logic [READ_PORTS*FWD_W-1:0]        forwardSelect;
    logic                               retireValid;
    modport master (
        output issueValid, stallRequest, flushValid, flushStage, decodeReadId,
               decodeWriteId, decodeWriteEnabled, decodeIsLoad,
        input  issueReady, stageValid, stageAdvance, hazardStall, forwardSelect, retireValid
    );
    modport slave (
        input  issueValid, stallRequest, flushValid, flushStage, decodeReadId,
               decodeWriteId, decodeWriteEnabled, decodeIsLoad,
        output issueReady, stageValid, stageAdvance, hazardStall, forwardSelect, retireValid
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: in-order pipeline valid/advance control with load-use stall and operand forwarding
// Ports: clock (rising edge), reset (asynchronous, active-low), bus (slave modport of pipeline_hazard_controller_if).
// Optional: define PIPELINE_PERF_COUNTERS_EN to add 32-bit wrapping outputs retireCount, stallCount
// (hazard-stall cycles) and flushCount (flush events).
module pipeline_hazard_controller #(
    parameter int STAGES       = 5,
    parameter int DECODE_STAGE = 1,
    parameter int READ_PORTS   = 2,
    parameter int REG_ID_WIDTH = 5
) (
    input  logic clock,
    input  logic reset,
    pipeline_hazard_controller_if.slave bus
`ifdef PIPELINE_PERF_COUNTERS_EN
    ,
    output logic [31:0] retireCount,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
`endif
);
    localparam int STAGE_W = $clog2(STAGES);
    localparam int FWD_W   = $clog2(STAGES + 1);
    localparam int FIRST   = DECODE_STAGE + 1;
    logic [STAGES-1:0]           valid, move, flushMask, incoming;
    logic [REG_ID_WIDTH-1:0]     wrId [FIRST:STAGES-1];
    logic [STAGES-1:FIRST]       wrEn, isLoad;
    logic [READ_PORTS*FWD_W-1:0] fwd;
    logic                        loadUse, hazard, issue;
    always_comb begin
        for (int i = 0; i < STAGES; i++)
            flushMask[i] = bus.flushValid && (STAGE_W'(i) < bus.flushStage);
    end
    // Scan oldest to youngest so the smallest matching stage overwrites older matches.
    always_comb begin
        fwd = '0;
        loadUse = 1'b0;
        for (int p = 0; p < READ_PORTS; p++) begin
            for (int j = STAGES - 1; j >= FIRST; j--)
                if (valid[j] && wrEn[j] && bus.decodeReadId[p*REG_ID_WIDTH +: REG_ID_WIDTH] != '0
                    && wrId[j] == bus.decodeReadId[p*REG_ID_WIDTH +: REG_ID_WIDTH])
                    fwd[p*FWD_W +: FWD_W] = FWD_W'(j);
            // A load directly ahead has no data yet: stall rather than forward.
            if (fwd[p*FWD_W +: FWD_W] == FWD_W'(FIRST) && isLoad[FIRST]) begin
                loadUse = 1'b1;
                fwd[p*FWD_W +: FWD_W] = '0;
            end
        end
    end
    assign hazard = loadUse && valid[DECODE_STAGE] && !flushMask[DECODE_STAGE] && !bus.stallRequest[DECODE_STAGE];
    // room: the stage ahead is empty or vacating this cycle (always true past the last stage).
    always_comb begin
        logic room;
        room = 1'b1;
        move = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            move[i] = valid[i] && !bus.stallRequest[i] && !(i == DECODE_STAGE && hazard) && room;
            room = !valid[i] || move[i];
        end
    end
    assign bus.issueReady    = !reset || ((!valid[0] || move[0]) && !bus.flushValid);
    assign issue             = bus.issueValid && bus.issueReady;
    assign incoming          = {move[STAGES-2:0], issue};
    assign bus.stageValid    = valid;
    assign bus.stageAdvance  = move;
    assign bus.hazardStall   = hazard;
    assign bus.forwardSelect = fwd;
    assign bus.retireValid   = move[STAGES-1];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid  <= '0;
            wrEn   <= '0;
            isLoad <= '0;
            for (int j = FIRST; j < STAGES; j++)
                wrId[j] <= '0;
        end else begin
            valid <= ~flushMask & (incoming | (valid & ~move));
            if (move[DECODE_STAGE]) begin
                wrId[FIRST]   <= bus.decodeWriteId;
                wrEn[FIRST]   <= bus.decodeWriteEnabled;
                isLoad[FIRST] <= bus.decodeIsLoad;
            end
            for (int j = FIRST + 1; j < STAGES; j++)
                if (move[j-1]) begin
                    wrId[j]   <= wrId[j-1];
                    wrEn[j]   <= wrEn[j-1];
                    isLoad[j] <= isLoad[j-1];
                end
        end
    end
`ifdef PIPELINE_PERF_COUNTERS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retireCount <= '0;
            stallCount  <= '0;
            flushCount  <= '0;
        end else begin
            retireCount <= retireCount + 32'(move[STAGES-1]);
            stallCount  <= stallCount + 32'(hazard);
            flushCount  <= flushCount + 32'(bus.flushValid);
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: randomized and directed checks against an instruction-slot reference model
module tb_pipeline_hazard_controller;
    localparam int S = 5;
    localparam int D = 1;
    typedef struct {
        bit         v;
        bit         en;
        bit         ld;
        logic [4:0] wid;
        logic [4:0] r0;
        logic [4:0] r1;
    } ins_t;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;
    pipeline_hazard_controller_if #(.STAGES(S), .READ_PORTS(2), .REG_ID_WIDTH(5)) bus ();
`ifdef PIPELINE_PERF_COUNTERS_EN
    logic [31:0] retireCount, stallCount, flushCount;
`endif
    pipeline_hazard_controller #(.STAGES(S), .DECODE_STAGE(D), .READ_PORTS(2), .REG_ID_WIDTH(5)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef PIPELINE_PERF_COUNTERS_EN
        ,
        .retireCount(retireCount),
        .stallCount(stallCount),
        .flushCount(flushCount)
`endif
    );
    ins_t        pipe [S];
    ins_t        cand;
    bit          fl [S];
    logic [4:0]  expValid, expAdv;
    bit          expReady, expHaz, expRetire;
    logic [2:0]  expFwd [2];
    int unsigned mRetire, mStall, mFlush;
    int          passed = 0;
    int          total = 0;
    function automatic ins_t mk(bit en, logic [4:0] wid, bit ld, logic [4:0] r0, logic [4:0] r1);
        ins_t x;
        x.v = 1'b1; x.en = en; x.wid = wid; x.ld = ld; x.r0 = r0; x.r1 = r1;
        return x;
    endfunction
    function automatic ins_t rnd();
        return mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    endfunction
    task automatic clearModel();
        for (int i = 0; i < S; i++) pipe[i] = '{default: 0};
        mRetire = 0; mStall = 0; mFlush = 0;
    endtask
    // Expected outputs for the current slot contents and inputs.
    task automatic evalModel();
        int best;
        bit ld, luse, room;
        logic [4:0] rid;
        luse = 1'b0;
        for (int i = 0; i < S; i++) fl[i] = bus.flushValid && i < int'(bus.flushStage);
        for (int p = 0; p < 2; p++) begin
            rid = (p == 0) ? pipe[D].r0 : pipe[D].r1;
            best = 0;
            for (int j = D + 1; j < S; j++)
                if (best == 0 && pipe[j].v && pipe[j].en && rid != 0 && pipe[j].wid == rid) best = j;
            ld = best == D + 1 && pipe[D+1].ld;
            luse |= ld;
            expFwd[p] = ld ? 3'd0 : 3'(best);
        end
        expHaz = luse && pipe[D].v && !fl[D] && !bus.stallRequest[D];
        room = 1'b1;
        for (int i = S - 1; i >= 0; i--) begin
            expAdv[i] = pipe[i].v && !bus.stallRequest[i] && !(i == D && expHaz) && room;
            room = !pipe[i].v || expAdv[i];
            expValid[i] = pipe[i].v;
        end
        expReady = (!pipe[0].v || expAdv[0]) && !bus.flushValid;
        expRetire = expAdv[S-1];
    endtask
    task automatic modelEdge();
        ins_t nx [S];
        for (int i = 0; i < S; i++) begin
            nx[i] = pipe[i];
            if (i == 0) begin
                if (bus.issueValid && expReady) nx[0] = cand;
                else if (expAdv[0]) nx[0].v = 1'b0;
            end else if (expAdv[i-1]) nx[i] = pipe[i-1];
            else if (expAdv[i]) nx[i].v = 1'b0;
            if (fl[i]) nx[i].v = 1'b0;
        end
        mRetire += 32'(expRetire);
        mStall += 32'(expHaz);
        mFlush += 32'(bus.flushValid);
        pipe = nx;
    endtask
    task automatic drive(bit iv, logic [4:0] st, bit fv, logic [2:0] fs);
        bus.issueValid = iv;
        bus.stallRequest = st;
        bus.flushValid = fv;
        bus.flushStage = fs;
        bus.decodeWriteId = pipe[D].wid;
        bus.decodeWriteEnabled = pipe[D].en;
        bus.decodeIsLoad = pipe[D].ld;
        bus.decodeReadId = {pipe[D].r1, pipe[D].r0};
        #1;
        evalModel();
    endtask
    task automatic step();
        @(posedge clock);
        #1;
        modelEdge();
    endtask
    task automatic doReset();
        reset = 1'b0;
        clearModel();
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask
    task automatic test_reset();
        clearModel();
        bus.issueValid = 1'b1; bus.stallRequest = '0; bus.flushValid = 1'b0; bus.flushStage = '0;
        bus.decodeReadId = {5'd2, 5'd1}; bus.decodeWriteId = 5'd1; bus.decodeWriteEnabled = 1'b1; bus.decodeIsLoad = 1'b1;
        #1;
        total++; if (bus.stageValid !== 5'b0) $display("FAIL reset stageValid got=%b exp=00000", bus.stageValid); else passed++;
        total++; if (bus.issueReady !== 1'b1) $display("FAIL reset issueReady got=%b exp=1", bus.issueReady); else passed++;
        total++; if (bus.stageAdvance !== 5'b0) $display("FAIL reset stageAdvance got=%b exp=00000", bus.stageAdvance); else passed++;
        total++; if (bus.hazardStall !== 1'b0) $display("FAIL reset hazardStall got=%b exp=0", bus.hazardStall); else passed++;
        total++; if (bus.forwardSelect !== 6'b0) $display("FAIL reset forwardSelect got=%h exp=0", bus.forwardSelect); else passed++;
        total++; if (bus.retireValid !== 1'b0) $display("FAIL reset retireValid got=%b exp=0", bus.retireValid); else passed++;
        @(posedge clock);
        #1;
        total++; if (bus.stageValid !== 5'b0) $display("FAIL reset held stageValid got=%b exp=00000", bus.stageValid); else passed++;
        reset = 1'b1;
    endtask
    task automatic test_fill();
        for (int k = 0; k < 9; k++) begin
            cand = mk(0, 5'd0, 0, 5'd0, 5'd0);
            drive(1, 5'b0, 0, 3'd0);
            total++; if (bus.retireValid !== (k >= 5)) $display("FAIL fill retireValid edges=%0d got=%b exp=%b", k, bus.retireValid, k >= 5); else passed++;
            total++; if (bus.stageValid !== expValid) $display("FAIL fill stageValid edges=%0d got=%b exp=%b", k, bus.stageValid, expValid); else passed++;
            total++; if (bus.issueReady !== 1'b1) $display("FAIL fill issueReady edges=%0d got=%b exp=1", k, bus.issueReady); else passed++;
            step();
        end
    endtask
    task automatic test_forward();
        doReset();
        for (int k = 0; k < 5; k++) begin
            cand = (k == 0) ? mk(1, 5'd3, 0, 5'd0, 5'd0) : mk(0, 5'd0, 0, 5'd3, 5'd0);
            drive(k < 2, 5'b0, 0, 3'd0);
            total++; if (bus.forwardSelect !== {expFwd[1], expFwd[0]}) $display("FAIL fwd model edges=%0d got=%h exp=%h", k, bus.forwardSelect, {expFwd[1], expFwd[0]}); else passed++;
            if (k == 3) begin
                total++; if (bus.forwardSelect[2:0] !== 3'd2) $display("FAIL fwd r3 port0 got=%0d exp=2", bus.forwardSelect[2:0]); else passed++;
                total++; if (bus.hazardStall !== 1'b0) $display("FAIL fwd hazardStall got=%b exp=0", bus.hazardStall); else passed++;
            end
            step();
        end
    endtask
    task automatic test_load_use();
        doReset();
        for (int k = 0; k < 6; k++) begin
            cand = (k == 0) ? mk(1, 5'd4, 1, 5'd0, 5'd0) : mk(0, 5'd0, 0, 5'd4, 5'd0);
            drive(k < 2, 5'b0, 0, 3'd0);
            total++; if (bus.hazardStall !== expHaz) $display("FAIL load model hazard edges=%0d got=%b exp=%b", k, bus.hazardStall, expHaz); else passed++;
            if (k == 3) begin
                total++; if (bus.hazardStall !== 1'b1) $display("FAIL load hazardStall got=%b exp=1", bus.hazardStall); else passed++;
                total++; if (bus.stageValid !== 5'b00110) $display("FAIL load stageValid got=%b exp=00110", bus.stageValid); else passed++;
            end
            if (k == 4) begin
                total++; if (bus.hazardStall !== 1'b0) $display("FAIL load hazard release got=%b exp=0", bus.hazardStall); else passed++;
                total++; if (bus.forwardSelect[2:0] !== 3'd3) $display("FAIL load fwd port0 got=%0d exp=3", bus.forwardSelect[2:0]); else passed++;
                total++; if (bus.stageValid !== 5'b01010) $display("FAIL load bubble stageValid got=%b exp=01010", bus.stageValid); else passed++;
            end
            step();
        end
    endtask
    task automatic test_flush();
        doReset();
        for (int k = 0; k < 5; k++) begin
            cand = mk(0, 5'd0, 0, 5'd0, 5'd0);
            drive(1, 5'b0, 0, 3'd0);
            step();
        end
        cand = mk(0, 5'd0, 0, 5'd0, 5'd0);
        drive(1, 5'b0, 1, 3'd2);
        total++; if (bus.stageValid !== 5'b11111) $display("FAIL flush full stageValid got=%b exp=11111", bus.stageValid); else passed++;
        total++; if (bus.issueReady !== 1'b0) $display("FAIL flush issueReady got=%b exp=0", bus.issueReady); else passed++;
        step();
        drive(0, 5'b0, 0, 3'd0);
        total++; if (bus.stageValid !== 5'b11100) $display("FAIL flush stageValid got=%b exp=11100", bus.stageValid); else passed++;
        step();
    endtask
    task automatic test_stall();
        doReset();
        for (int k = 0; k < 5; k++) begin
            cand = mk(1, 5'd0, 0, 5'd0, 5'd0);
            drive(1, 5'b0, 0, 3'd0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            cand = mk(1, 5'd0, 0, 5'd0, 5'd0);
            drive(1, 5'b01000, 0, 3'd0);
            total++; if (bus.retireValid !== (k == 0)) $display("FAIL stall retireValid cyc=%0d got=%b exp=%b", k, bus.retireValid, k == 0); else passed++;
            total++; if (bus.stageAdvance !== (k == 0 ? 5'b10000 : 5'b00000)) $display("FAIL stall stageAdvance cyc=%0d got=%b", k, bus.stageAdvance); else passed++;
            total++; if (bus.issueReady !== 1'b0) $display("FAIL stall issueReady cyc=%0d got=%b exp=0", k, bus.issueReady); else passed++;
            total++; if (bus.forwardSelect !== 6'b0) $display("FAIL stall r0 forwardSelect cyc=%0d got=%h exp=0", k, bus.forwardSelect); else passed++;
            step();
            total++; if (bus.stageValid !== 5'b01111) $display("FAIL stall stageValid cyc=%0d got=%b exp=01111", k, bus.stageValid); else passed++;
        end
        drive(0, 5'b0, 0, 3'd0);
        total++; if (bus.stageAdvance !== 5'b01111) $display("FAIL stall release stageAdvance got=%b exp=01111", bus.stageAdvance); else passed++;
        step();
    endtask
    task automatic test_random(int cycles);
        for (int c = 0; c < cycles; c++) begin
            cand = rnd();
            drive($urandom_range(0, 3) != 0,
                  5'({$urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0}),
                  $urandom_range(0, 9) == 0, 3'($urandom_range(1, 4)));
            total++; if (bus.stageValid !== expValid) $display("FAIL rnd stageValid cyc=%0d got=%b exp=%b", c, bus.stageValid, expValid); else passed++;
            total++; if (bus.stageAdvance !== expAdv) $display("FAIL rnd stageAdvance cyc=%0d got=%b exp=%b", c, bus.stageAdvance, expAdv); else passed++;
            total++; if (bus.issueReady !== expReady) $display("FAIL rnd issueReady cyc=%0d got=%b exp=%b", c, bus.issueReady, expReady); else passed++;
            total++; if (bus.hazardStall !== expHaz) $display("FAIL rnd hazardStall cyc=%0d got=%b exp=%b", c, bus.hazardStall, expHaz); else passed++;
            total++; if (bus.forwardSelect !== {expFwd[1], expFwd[0]}) $display("FAIL rnd forwardSelect cyc=%0d got=%h exp=%h", c, bus.forwardSelect, {expFwd[1], expFwd[0]}); else passed++;
            total++; if (bus.retireValid !== expRetire) $display("FAIL rnd retireValid cyc=%0d got=%b exp=%b", c, bus.retireValid, expRetire); else passed++;
            step();
        end
`ifdef PIPELINE_PERF_COUNTERS_EN
        total++; if (retireCount !== mRetire) $display("FAIL rnd retireCount got=%0d exp=%0d", retireCount, mRetire); else passed++;
        total++; if (stallCount !== mStall) $display("FAIL rnd stallCount got=%0d exp=%0d", stallCount, mStall); else passed++;
        total++; if (flushCount !== mFlush) $display("FAIL rnd flushCount got=%0d exp=%0d", flushCount, mFlush); else passed++;
`endif
    endtask
    task automatic test_reset_midstream();
        test_random(20);
        #2;
        reset = 1'b0;
        clearModel();
        #1;
        total++; if (bus.stageValid !== 5'b0) $display("FAIL midreset stageValid got=%b exp=00000", bus.stageValid); else passed++;
        total++; if (bus.issueReady !== 1'b1) $display("FAIL midreset issueReady got=%b exp=1", bus.issueReady); else passed++;
        total++; if (bus.retireValid !== 1'b0) $display("FAIL midreset retireValid got=%b exp=0", bus.retireValid); else passed++;
`ifdef PIPELINE_PERF_COUNTERS_EN
        total++; if ({retireCount, stallCount, flushCount} !== 96'b0) $display("FAIL midreset counters got=%0d/%0d/%0d exp=0", retireCount, stallCount, flushCount); else passed++;
`endif
        @(posedge clock);
        #2;
        reset = 1'b1;
        test_random(30);
    endtask
    initial begin
        test_reset();
        test_fill();
        test_forward();
        test_load_use();
        test_flush();
        test_stall();
        doReset();
        test_random(500);
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter STAGES, default 5, number of pipeline stages (min 3; stage 0 = fetch, STAGES-1 = write back).
REQ-002 SHALL have parameter DECODE_STAGE, default 1, stage where register reads and hazard checks occur (1..STAGES-2).
REQ-003 SHALL have parameter READ_PORTS, default 2, source operands checked per instruction.
REQ-004 SHALL have parameter REG_ID_WIDTH, default 5, register id width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- issueValid  input  1  fetch offers an instruction
- issueReady  output  1  stage 0 accepts it this cycle
- stallRequest  input  STAGES  per-stage external hold
- flushValid  input  1  jump resolved this cycle
- flushStage  input  clog2(STAGES)  stage resolving the jump (> 0)
- decodeReadId  input  READ_PORTS*REG_ID_WIDTH  source ids in decode stage
- decodeWriteId  input  REG_ID_WIDTH  destination id in decode stage
- decodeWriteEnabled  input  1  decode instruction writes a register
- decodeIsLoad  input  1  decode instruction result available only after its memory stage
- stageValid  output  STAGES  stage holds a live instruction
- stageAdvance  output  STAGES  load enable for each stage's output register
- hazardStall  output  1  load-use stall active in decode
- forwardSelect  output  READ_PORTS*clog2(STAGES+1)  per port: 0 = register file, k = forward from stage k
- retireValid  output  1  last stage retires this cycle

Function
REQ-007 Stage i SHALL move to i+1 when stageValid[i], !stallRequest[i], !hazard-hold[i], and stage i+1 empty or moving; stageAdvance[i] asserts exactly then.
REQ-008 Last stage SHALL retire (retireValid=1) when valid and !stallRequest[STAGES-1]; a vacated stage with no incoming instruction SHALL clear its valid bit (bubble).
REQ-009 issueReady SHALL equal stage 0 empty-or-moving, with no flush this cycle; issue handshake = issueValid && issueReady.
REQ-010 On stageAdvance[DECODE_STAGE], entry DECODE_STAGE+1 SHALL capture decodeWriteId, decodeWriteEnabled, decodeIsLoad; metadata shifts with valid bits thereafter.
REQ-011 Hazard match for port p: valid stage j > DECODE_STAGE, writeEnabled, writeId == readId[p], readId[p] != 0; youngest (smallest j) match wins.
REQ-012 If winning match is a load in stage DECODE_STAGE+1, hazardStall SHALL assert, decode SHALL hold, and a bubble SHALL enter DECODE_STAGE+1; otherwise forwardSelect[p] = j.
REQ-013 No match, or readId[p]==0, SHALL give forwardSelect[p]=0; forwardSelect SHALL be combinational from current state and inputs (zero latency).
REQ-014 flushValid SHALL clear stageValid[0..flushStage-1] at the next edge and block issue; stage flushStage and older proceed normally.
REQ-015 Priority SHALL be flush > stallRequest > hazard stall; hazardStall SHALL be 0 when decode is flushed.
REQ-016 Stalls SHALL propagate upstream only; older stages SHALL keep draining.

Reset
REQ-017 Asynchronous assertion SHALL clear stageValid and all metadata; issueReady=1, stageAdvance=0, hazardStall=0, forwardSelect=0, retireValid=0 while reset is low.
REQ-018 Reset mid-operation SHALL discard all in-flight instructions; first issue accepted on the first rising edge after deassertion.

Configuration
REQ-019 Macro PIPELINE_PERF_COUNTERS_EN SHALL add 32-bit outputs retireCount, stallCount (hazard cycles), flushCount (flush events), wrapping at 2^32, reset to 0.
REQ-020 Without PIPELINE_PERF_COUNTERS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification (STAGES=5, DECODE_STAGE=1, READ_PORTS=2)
REQ-021 Issue every cycle, no stalls -> first retireValid on 5th edge after first issue, then one per cycle.
REQ-022 Decode writes r3 (non-load), next instruction reads r3 -> forwardSelect[0]=2, hazardStall=0.
REQ-023 Load writes r4, next reads r4 -> hazardStall=1 one cycle, bubble in stage 2, then forwardSelect[0]=3.
REQ-024 flushValid with flushStage=2 while stages 0-4 valid -> stageValid=5'b11100 next cycle, issueReady=0 that cycle.
REQ-025 stallRequest[3]=1 for 2 cycles with full pipeline -> stages 0-3 hold, stage 4 retires then empties; readId r0 always selects 0.
REQ-026 reset low mid-stream -> stageValid=0 immediately, counters 0 (PIPELINE_PERF_COUNTERS_EN).
